uncached_access_unit: RTL and testbench
=======================================

// Module: uncached_access_unit
// PURPOSE
//  Slave of the uncached half of cpu_dbus_if (uncached_read/write/stall/rddata);
//  posts uncached stores into a small write buffer and performs single-beat
//  uncached loads on a downstream memory request port. Loads are ordered after all
//  buffered stores (full drain before issue). Sits between the CPU MEM stage and
//  the bus/AXI bridge, alongside the D$ that serves the cached half of the bus.
// PARAMETERS
//  WBUF_DEPTH  4  write-buffer entries; power of two, >= 2
// PORTS
//  clk              in   1   sole clock; all state updates on rising edge
//  rst              in   1   synchronous, active-high reset
//  uncached_read    in   1   CPU uncached load request; held until stall low
//  uncached_write   in   1   CPU uncached store request; held until stall low
//  address          in   32  phys_t, 4-byte aligned
//  wrdata           in   32  store data
//  byteenable       in   4   store byte lanes
//  uncached_stall   out  1   request not yet accepted/completed this cycle
//  uncached_rddata  out  32  load data, valid in the cycle stall drops for a read
//  mem_req          out  1   downstream request valid
//  mem_we           out  1   1 = write, 0 = read
//  mem_addr         out  32  request address
//  mem_wdata        out  32  write data
//  mem_be           out  4   write byte enables (4'hF on reads)
//  mem_ready        in   1   downstream accepts request this cycle
//  mem_rvalid       in   1   read response valid (one pulse per read)
//  mem_rdata        in   32  read response data
// BEHAVIOUR
//  Reset: FIFO emptied (ptrs/count 0), FSM=IDLE; outputs mem_req=0, mem_we=0,
//   mem_addr/wdata=0, mem_be=0, uncached_stall=0, uncached_rddata=0.
//  Writes: in IDLE, uncached_write & !full -> push {address,wrdata,byteenable},
//   stall=0 same cycle (0-cycle accept). Full -> stall=1; no push. Stall is
//   decided from registered full only (no comb path from mem_ready); a pop in the
//   same cycle does not relieve stall until next cycle.
//  Drain: FIFO non-empty -> mem_req=1, mem_we=1, fields from head; pop on
//   mem_req&mem_ready. Write complete on acceptance (no response). Push and pop in
//   one cycle allowed when not full: count unchanged, both ptrs advance, mod DEPTH.
//  Reads, FSM (IDLE,RD_DRAIN,RD_REQ,RD_RESP,RD_DONE):
//   IDLE: uncached_read -> stall=1; -> RD_DRAIN (addr latched).
//   RD_DRAIN: stall=1; FIFO empty (incl. last pop accepted) -> RD_REQ next cycle.
//   RD_REQ: mem_req=1, mem_we=0, mem_be=4'hF; mem_ready -> RD_RESP.
//   RD_RESP: stall=1; mem_rvalid -> capture mem_rdata to uncached_rddata -> RD_DONE.
//   RD_DONE: stall=0 (CPU consumes data, advances) -> IDLE. rddata holds till next read.
//  Minimum read latency from request with empty FIFO, mem_ready=1, rvalid next
//   cycle: stall high 3 cycles, data presented in 4th.
//  New writes not accepted while FSM != IDLE (stall=1 on uncached_write).
//  mem_* outputs stable while mem_req=1 & !mem_ready.
//  uncached_read & uncached_write together is illegal (bench assertion); read wins.
//  Reset mid-operation: buffered stores discarded, FSM->IDLE; downstream shares rst.
// STRUCTURE
//  Shared package: uncached_req_t {phys_t addr; uint32_t data; logic [3:0] be},
//   uncached_state_t enum. Sub-module: uncached_wbuf (sync FIFO of uncached_req_t,
//   push/pop/full/empty/head, WBUF_DEPTH). FSM + mux in this module.
// TESTING
//  4 writes 0x1fd0_0000..0c, mem_ready=0 -> no stall, FIFO full; 5th write stalls
//   until first pop, then accepted; 5 mem writes in order, be preserved.
//  Read 0x1fd0_0010 with 2 buffered writes -> both writes issued first; read issued
//   after; mem_rdata=0xDEAD_BEEF -> uncached_rddata=0xDEAD_BEEF when stall drops.
//  Read, empty FIFO, mem_ready=1, rvalid 1 cycle later -> stall high exactly 3 cycles.
//  20 back-to-back writes, mem_ready toggling 1/0 -> pointer wrap, exact order, no loss.
//  rst during RD_RESP -> next cycle stall=0, mem_req=0, FIFO empty, FSM IDLE.
//  mem_ready=0 for 5 cycles during drain -> mem_addr/wdata/be unchanged throughout.

Source files
------------

// File: rtl/uncached_access_unit_pkg.sv
// Shared types for the uncached access unit: bus widths, the buffered store
// record and the read-sequencing state encoding.
package uncached_access_unit_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef logic [ADDR_W-1:0] phys_t;
    typedef logic [DATA_W-1:0] uint32_t;

    // One posted uncached store
    typedef struct packed {
        phys_t           addr;
        uint32_t         data;
        logic [BE_W-1:0] be;
    } uncached_req_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_DRAIN,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_RD_DONE
    } uncached_state_t;

endpackage

// File: rtl/uncached_wbuf.sv
// Synchronous FIFO of posted uncached stores.
// Ports: clk, rst (sync, active-high); push/push_data write the tail when not
// full; pop retires the head when not empty; head is the oldest entry;
// full/empty/one_left are registered occupancy flags.
module uncached_wbuf
    import uncached_access_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  uncached_req_t push_data,
    input  logic          pop,
    output uncached_req_t head,
    output logic          full,
    output logic          empty,
    output logic          one_left
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    uncached_req_t    entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head     = entries[rd_ptr];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign one_left = (count == CNT_W'(1));

endmodule

// File: rtl/uncached_access_unit.sv
// Uncached half of the CPU data bus: posts stores into a write buffer that
// drains to the downstream memory port, and runs single-beat loads that are
// ordered behind every buffered store.
// Ports: clk, rst (sync, active-high); CPU side uncached_read/uncached_write,
// address, wrdata, byteenable in, uncached_stall/uncached_rddata out; memory
// side mem_req/mem_we/mem_addr/mem_wdata/mem_be out with mem_ready handshake,
// mem_rvalid/mem_rdata read response in.
module uncached_access_unit
    import uncached_access_unit_pkg::*;
#(
    parameter int unsigned WBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uncached_read,
    input  logic              uncached_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wrdata,
    input  logic [BE_W-1:0]   byteenable,
    output logic              uncached_stall,
    output logic [DATA_W-1:0] uncached_rddata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    uncached_state_t state;
    phys_t           rd_addr;
    uncached_req_t   wr_req;
    uncached_req_t   head;
    logic            wb_push;
    logic            wb_pop;
    logic            wb_full;
    logic            wb_empty;
    logic            wb_one_left;
    logic            drained;

    assign wr_req = '{addr: address, data: wrdata, be: byteenable};

    // Stores are taken only in IDLE; a simultaneous read takes precedence
    assign wb_push = (state == ST_IDLE) && uncached_write && !uncached_read && !wb_full;
    // Whenever the buffer holds data its head is on the port, so ready pops it
    assign wb_pop  = !wb_empty && mem_ready;
    // Buffer is empty now or becomes empty at this edge
    assign drained = wb_empty || (wb_pop && wb_one_left);

    uncached_wbuf #(
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (wb_push),
        .push_data (wr_req),
        .pop       (wb_pop),
        .head      (head),
        .full      (wb_full),
        .empty     (wb_empty),
        .one_left  (wb_one_left)
    );

    // Read sequencing; the drain wait is skipped when nothing is buffered
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            rd_addr         <= '0;
            uncached_rddata <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (uncached_read) begin
                        rd_addr <= address;
                        state   <= drained ? ST_RD_REQ : ST_RD_DRAIN;
                    end
                end
                ST_RD_DRAIN: begin
                    if (drained) begin
                        state <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (mem_ready) begin
                        state <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (mem_rvalid) begin
                        uncached_rddata <= mem_rdata;
                        state           <= ST_RD_DONE;
                    end
                end
                ST_RD_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall uses only registered full, never the downstream handshake
    always_comb begin
        uncached_stall = 1'b1;
        unique case (state)
            ST_IDLE:    uncached_stall = uncached_read || (uncached_write && wb_full);
            ST_RD_DONE: uncached_stall = 1'b0;
            default:    uncached_stall = 1'b1;
        endcase
    end

    // Downstream port is driven purely from registered state, so it holds
    // steady until accepted
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (state == ST_RD_REQ) begin
            mem_req  = 1'b1;
            mem_addr = rd_addr;
            mem_be   = '1;
        end else if (!wb_empty) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = head.addr;
            mem_wdata = head.data;
            mem_be    = head.be;
        end
    end

endmodule

// File: tb/tb_uncached_access_unit.sv
// Bench for uncached_access_unit: a transaction-level scoreboard predicts the
// order and content of downstream requests, buffer occupancy predicts store
// stalls, and the memory responder supplies the expected load data.
module tb_uncached_access_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        uncached_read;
    logic        uncached_write;
    logic [31:0] address;
    logic [31:0] wrdata;
    logic [3:0]  byteenable;
    logic        uncached_stall;
    logic [31:0] uncached_rddata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    uncached_access_unit #(
        .WBUF_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .uncached_read   (uncached_read),
        .uncached_write  (uncached_write),
        .address         (address),
        .wrdata          (wrdata),
        .byteenable      (byteenable),
        .uncached_stall  (uncached_stall),
        .uncached_rddata (uncached_rddata),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_be          (mem_be),
        .mem_ready       (mem_ready),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(uncached_read && uncached_write))
                else $error("illegal simultaneous uncached read and write");
        end
    end

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } txn_t;

    txn_t        exp_q[$];
    int          occ;
    int          total;
    int          bad;
    int          ready_mode;
    bit          tog;
    int          rv_cnt;
    int          rv_delay;
    bit          force_rd;
    logic [31:0] force_val;
    logic [31:0] exp_rdata;
    logic        s_stall;
    logic [31:0] s_rddata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ready_val();
        case (ready_mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return tog;
            default: return 1'($urandom % 2);
        endcase
    endfunction

    task automatic set_ready(input int m);
        ready_mode = m;
        mem_ready  = ready_val();
    endtask

    // One clock: observe at the falling edge, drive the memory side after the rising edge
    task automatic tick();
        txn_t t;
        @(negedge clk);
        s_stall  = uncached_stall;
        s_rddata = uncached_rddata;
        if (uncached_write) begin
            chk("wr_stall", 32'(uncached_stall), 32'(occ == DEPTH));
        end
        if (exp_q.size() == 0) begin
            chk("idle_req", 32'(mem_req), 32'(0));
        end else if (mem_req) begin
            t = exp_q[0];
            chk("mem_we", 32'(mem_we), 32'(t.we));
            chk("mem_addr", mem_addr, t.addr);
            if (t.we) begin
                chk("mem_wdata", mem_wdata, t.data);
                chk("mem_be", 32'(mem_be), 32'(t.be));
            end else begin
                chk("mem_be_rd", 32'(mem_be), 32'(4'hF));
            end
            if (mem_ready) begin
                void'(exp_q.pop_front());
                if (t.we) begin
                    occ--;
                end else begin
                    rv_cnt    = rv_delay;
                    exp_rdata = force_rd ? force_val : $urandom;
                end
            end
        end
        if (uncached_write && !uncached_stall) begin
            exp_q.push_back('{we: 1'b1, addr: address, data: wrdata, be: byteenable});
            occ++;
        end
        @(posedge clk);
        #1;
        tog        = ~tog;
        mem_ready  = ready_val();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = exp_rdata;
            end
        end
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, output int stalls);
        bit done;
        uncached_write = 1'b1;
        address        = a;
        wrdata         = d;
        byteenable     = be;
        stalls         = 0;
        done           = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            if (s_stall) stalls++;
            else done = 1'b1;
        end
        if (!done) chk("wr_timeout", 32'(done), 32'(1));
        uncached_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output int stalls);
        bit done;
        exp_q.push_back('{we: 1'b0, addr: a, data: 32'h0, be: 4'hF});
        uncached_read = 1'b1;
        address       = a;
        stalls        = 0;
        done          = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            if (s_stall) begin
                stalls++;
            end else begin
                done = 1'b1;
                chk("rd_data", s_rddata, exp_rdata);
            end
        end
        if (!done) chk("rd_timeout", 32'(done), 32'(1));
        uncached_read = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        chk("drain", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic apply_reset();
        rst            = 1'b1;
        uncached_read  = 1'b0;
        uncached_write = 1'b0;
        mem_rvalid     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        occ    = 0;
        rv_cnt = 0;
    endtask

    logic [31:0] a;
    logic [31:0] last_rd;
    int          n;

    initial begin
        total = 0; bad = 0; occ = 0; rv_cnt = 0; rv_delay = 1;
        tog = 1'b0; force_rd = 1'b0; force_val = 32'h0; exp_rdata = 32'h0;
        ready_mode = 1;
        rst = 1'b1; uncached_read = 1'b0; uncached_write = 1'b0;
        address = 32'h0; wrdata = 32'h0; byteenable = 4'h0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(uncached_stall), 32'(0));
        chk("rst_rddata", uncached_rddata, 32'h0);
        chk("rst_req", 32'(mem_req), 32'(0));
        chk("rst_we", 32'(mem_we), 32'(0));
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_be", 32'(mem_be), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill the buffer with the port blocked, then a fifth store waits for a pop
        set_ready(1);
        for (int i = 0; i < 4; i++) begin
            a = 32'h1fd0_0000 + 32'(i * 4);
            cpu_write(a, 32'hA000_0000 + 32'(i), 4'(1 << i), n);
            chk("wr_fill_nostall", 32'(n), 32'(0));
        end
        uncached_write = 1'b1;
        address = 32'h1fd0_0010; wrdata = 32'hA000_0004; byteenable = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_stall", 32'(s_stall), 32'(1));
        end
        set_ready(0);
        cpu_write(32'h1fd0_0010, 32'hA000_0004, 4'b1010, n);
        chk("wr5_stalls", 32'(n), 32'(1));
        wait_drain();

        // Load behind two buffered stores
        set_ready(1);
        cpu_write(32'h1fd0_0020, 32'h1111_2222, 4'b0011, n);
        cpu_write(32'h1fd0_0024, 32'h3333_4444, 4'b1100, n);
        chk("occ_before_rd", 32'(occ), 32'(2));
        force_rd = 1'b1; force_val = 32'hDEAD_BEEF;
        set_ready(0);
        cpu_read(32'h1fd0_0010, n);
        chk("rd_deadbeef", s_rddata, 32'hDEAD_BEEF);
        force_rd = 1'b0;

        // Minimum load latency
        rv_delay = 1;
        cpu_read(32'h1fd0_0030, n);
        chk("rd_latency", 32'(n), 32'(3));
        last_rd = exp_rdata;
        cpu_write(32'h1fd0_0040, 32'h5555_6666, 4'hF, n);
        tick();
        chk("rddata_hold", s_rddata, last_rd);
        wait_drain();

        // Twenty back-to-back stores with an alternating ready
        set_ready(2);
        for (int i = 0; i < 20; i++) begin
            cpu_write(32'h1fd1_0000 + 32'(i * 4), $urandom, 4'($urandom), n);
        end
        wait_drain();

        // Blocked drain must hold the request fields
        set_ready(1);
        cpu_write(32'h1fd0_0050, 32'hCAFE_F00D, 4'b0110, n);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_req", 32'(mem_req), 32'(1));
        end
        set_ready(0);
        wait_drain();

        // Random mix of stores and loads
        for (int k = 0; k < 60; k++) begin
            set_ready(($urandom % 3 == 0) ? 0 : int'($urandom_range(2, 3)));
            rv_delay = int'($urandom_range(1, 3));
            a = 32'h1fd0_0000 + {22'h0, 8'($urandom), 2'b00};
            if ($urandom % 4 == 0) cpu_read(a, n);
            else cpu_write(a, $urandom, 4'($urandom), n);
            repeat ($urandom % 2) tick();
        end
        set_ready(0);
        wait_drain();

        // Reset while waiting for a load response
        rv_delay = 20;
        exp_q.push_back('{we: 1'b0, addr: 32'h1fd0_0060, data: 32'h0, be: 4'hF});
        uncached_read = 1'b1;
        address = 32'h1fd0_0060;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("rd_issued", 32'(exp_q.size()), 32'(0));
        apply_reset();
        tick();
        chk("rst_mid_stall", 32'(s_stall), 32'(0));
        chk("rst_mid_req", 32'(mem_req), 32'(0));
        chk("rst_mid_rddata", s_rddata, 32'h0);
        rv_delay = 1;
        cpu_write(32'h1fd0_0070, 32'h7777_8888, 4'hF, n);
        chk("rst_mid_idle", 32'(n), 32'(0));
        wait_drain();

        // Reset discards buffered stores
        set_ready(1);
        for (int i = 0; i < 3; i++) begin
            cpu_write(32'h1fd0_0080 + 32'(i * 4), $urandom, 4'hF, n);
        end
        apply_reset();
        set_ready(0);
        tick();
        chk("rst_discard", 32'(mem_req), 32'(0));
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
